// File: rtl/fft_pkg.sv
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared widths and defaults for the radix-2 butterfly post stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;
  localparam int DATA_W              = 8;   // Q0.7 samples
  localparam int TW_W                = 9;   // Q1.7 twiddles, +1.0 = 128
  localparam int PROD_W              = 17;  // twiddle * sample product
  localparam int TW_FRAC             = 7;
  localparam int BUTTERFLIES_DEFAULT = 16;
  localparam int MULT_LAT_DEFAULT    = 2;
  localparam int SUM_W               = 18;  // product sum before rescale
  localparam int T_W                 = 11;  // rescaled twiddle product
  localparam int RS_W                = 12;  // butterfly add/sub width

  function automatic logic signed [SUM_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction
endpackage

`default_nettype wire

// File: rtl/fft_round_sat.sv
// ============================================================================
// Module   : fft_round_sat
// Purpose  : (a +/- b + 1) >>> 1, clamped to DATA_W bits with saturate flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_round_sat
  import fft_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [T_W-1:0]    i_b,
  input  logic                     i_sub,
  output logic signed [DATA_W-1:0] o_y,
  output logic                     o_sat
);

  localparam logic signed [RS_W-1:0] c_MAX = RS_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [RS_W-1:0] c_MIN = RS_W'(-(2 ** (DATA_W - 1)));

  logic signed [RS_W-1:0] w_a;
  logic signed [RS_W-1:0] w_b;
  logic signed [RS_W-1:0] w_s;
  logic signed [RS_W-1:0] w_sh;

  assign w_a  = {{(RS_W-DATA_W){i_a[DATA_W-1]}}, i_a};
  assign w_b  = {{(RS_W-T_W){i_b[T_W-1]}}, i_b};
  assign w_s  = i_sub ? (w_a - w_b + RS_W'(1)) : (w_a + w_b + RS_W'(1));
  assign w_sh = w_s >>> 1;

  always_comb begin
    o_y   = w_sh[DATA_W-1:0];
    o_sat = 1'b0;
    if (w_sh > c_MAX) begin
      o_y   = c_MAX[DATA_W-1:0];
      o_sat = 1'b1;
    end else if (w_sh < c_MIN) begin
      o_y   = c_MIN[DATA_W-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fft_butterfly_post.sv
// ============================================================================
// Module   : fft_butterfly_post
// Purpose  : Butterfly back end: aligns x0 with twiddle products, rescales,
//            forms y0 = x0 + W*x1 and y1 = x0 - W*x1 with saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_butterfly_post
  import fft_pkg::*;
#(
  parameter int BUTTERFLIES = BUTTERFLIES_DEFAULT,
  parameter int MULT_LAT    = MULT_LAT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x0_re,
  input  logic signed [DATA_W-1:0] x0_im,
  input  logic signed [PROD_W-1:0] p_rr,
  input  logic signed [PROD_W-1:0] p_ii,
  input  logic signed [PROD_W-1:0] p_ri,
  input  logic signed [PROD_W-1:0] p_ir,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y0_re,
  output logic signed [DATA_W-1:0] y0_im,
  output logic signed [DATA_W-1:0] y1_re,
  output logic signed [DATA_W-1:0] y1_im,
  output logic                     out_last,
  output logic                     sat_sticky
);

  localparam int c_CNT_W = (BUTTERFLIES > 1) ? $clog2(BUTTERFLIES) : 1;
  localparam logic [c_CNT_W-1:0]  c_LAST = c_CNT_W'(BUTTERFLIES - 1);
  localparam logic [SUM_W-1:0]    c_RND  = SUM_W'(1 << (TW_FRAC - 1));

  // x0 / valid alignment with the multiplier latency
  logic [MULT_LAT-1:0]      r_dv;
  logic signed [DATA_W-1:0] r_dre [MULT_LAT];
  logic signed [DATA_W-1:0] r_dim [MULT_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dv <= '0;
    end else begin
      r_dv[0] <= in_valid;
      for (int i = 1; i < MULT_LAT; i++) r_dv[i] <= r_dv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_dre[0] <= x0_re;
    r_dim[0] <= x0_im;
    for (int i = 1; i < MULT_LAT; i++) begin
      r_dre[i] <= r_dre[i-1];
      r_dim[i] <= r_dim[i-1];
    end
  end

  // Stage A: complex product rescale from Q1.14 to Q?.7 with round-half-up
  logic signed [SUM_W-1:0]  w_sum_re;
  logic signed [SUM_W-1:0]  w_sum_im;
  logic                     r_a_v;
  logic signed [DATA_W-1:0] r_a_xre;
  logic signed [DATA_W-1:0] r_a_xim;
  logic signed [T_W-1:0]    r_a_tre;
  logic signed [T_W-1:0]    r_a_tim;

  assign w_sum_re = sext_prod(p_rr) - sext_prod(p_ii) + c_RND;
  assign w_sum_im = sext_prod(p_ri) + sext_prod(p_ir) + c_RND;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_a_v <= 1'b0;
    else          r_a_v <= r_dv[MULT_LAT-1];
  end

  always_ff @(posedge clk) begin
    r_a_xre <= r_dre[MULT_LAT-1];
    r_a_xim <= r_dim[MULT_LAT-1];
    r_a_tre <= T_W'(w_sum_re >>> TW_FRAC);
    r_a_tim <= T_W'(w_sum_im >>> TW_FRAC);
  end

  // Stage B: butterfly add/subtract with halving and saturation
  logic signed [DATA_W-1:0] w_y0_re;
  logic signed [DATA_W-1:0] w_y0_im;
  logic signed [DATA_W-1:0] w_y1_re;
  logic signed [DATA_W-1:0] w_y1_im;
  logic [3:0]               w_sat;

  fft_round_sat u_y0_re (.i_a(r_a_xre), .i_b(r_a_tre), .i_sub(1'b0), .o_y(w_y0_re), .o_sat(w_sat[0]));
  fft_round_sat u_y0_im (.i_a(r_a_xim), .i_b(r_a_tim), .i_sub(1'b0), .o_y(w_y0_im), .o_sat(w_sat[1]));
  fft_round_sat u_y1_re (.i_a(r_a_xre), .i_b(r_a_tre), .i_sub(1'b1), .o_y(w_y1_re), .o_sat(w_sat[2]));
  fft_round_sat u_y1_im (.i_a(r_a_xim), .i_b(r_a_tim), .i_sub(1'b1), .o_y(w_y1_im), .o_sat(w_sat[3]));

  logic                     r_ov;
  logic                     r_olast;
  logic                     r_sticky;
  logic [c_CNT_W-1:0]       r_cnt;
  logic signed [DATA_W-1:0] r_y0_re;
  logic signed [DATA_W-1:0] r_y0_im;
  logic signed [DATA_W-1:0] r_y1_re;
  logic signed [DATA_W-1:0] r_y1_im;

  // r_cnt holds the frame index of the next butterfly to be output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ov     <= 1'b0;
      r_olast  <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_y0_re  <= '0;
      r_y0_im  <= '0;
      r_y1_re  <= '0;
      r_y1_im  <= '0;
    end else begin
      r_ov    <= r_a_v;
      r_olast <= r_a_v && (r_cnt == c_LAST);
      if (r_a_v) begin
        r_y0_re <= w_y0_re;
        r_y0_im <= w_y0_im;
        r_y1_re <= w_y1_re;
        r_y1_im <= w_y1_im;
        r_cnt   <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
        if (|w_sat) r_sticky <= 1'b1;
      end
    end
  end

  assign out_valid  = r_ov;
  assign out_last   = r_olast;
  assign sat_sticky = r_sticky;
  assign y0_re      = r_y0_re;
  assign y0_im      = r_y0_im;
  assign y1_re      = r_y1_re;
  assign y1_im      = r_y1_im;

endmodule

`default_nettype wire
